seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
Controller for a programmable serial pattern detector. Software configures it with a pattern, an overlap mode and a target match count. A start command then arms it. It watches a qualified serial bit stream and counts pattern hits, then raises done when the target count is reached. This block sequences and configures the detection datapath that sits alongside the fixed Moore detectors in the sequence-detector family.

Parameters:
PAT_W, 4, pattern length in bits (2..8)
CNT_W, 8, width of match counter and target
RST_PAT, 4'b1110, pattern loaded at reset (width PAT_W)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-low
cfg_we  input  1  configuration write strobe, honoured only in IDLE
cfg_pattern  input  PAT_W  pattern to detect; MSB is the oldest bit
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cfg_target  input  CNT_W  number of matches needed to finish
start  input  1  arm command, honoured only in IDLE
abort  input  1  cancel a run
in  input  1  serial data bit
in_valid  input  1  qualifies in; bit is sampled only when high
busy  output  1  high in ARM/RUN
match  output  1  one-cycle pulse per detected pattern
match_cnt  output  CNT_W  matches counted in the current or last run
done  output  1  one-cycle pulse when the target is reached

Behaviour:
- Reset (rst low, async): state=IDLE; pattern=RST_PAT, overlap=0, target=1; history=0, fill=0; busy=0, match=0, match_cnt=0, done=0.
- All outputs are registered (Moore). No combinational path from any input to any output.
- FSM states: IDLE, ARM, RUN, DONE.
- IDLE:
  - cfg_we latches pattern/overlap/target on the clock edge.
  - start: go to ARM; clear history, fill and match_cnt.
  - abort in IDLE: no effect, and it overrides start in the same cycle (stay IDLE).
  - cfg_we and start in the same cycle: the new configuration is latched and used for this run.
- ARM: lasts one cycle, busy=1, in is ignored.
  - If target==0: go to DONE.
  - Otherwise go to RUN.
- RUN, on each cycle with in_valid=1:
  - history <= {history[PAT_W-2:0], in}.
  - fill saturates at PAT_W.
  - Hit = (fill_next==PAT_W) && (history_next==pattern).
  - On a hit:
    - match=1 in the following cycle.
    - match_cnt increments.
    - Non-overlap mode: fill is cleared to 0, so the next hit needs PAT_W fresh bits.
    - Overlap mode: fill is kept.
  - When in_valid=0, history and fill hold.
  - start, cfg_we: ignored.
- RUN exit:
  - abort: go to IDLE on the next edge; no done pulse; match_cnt holds its value; a hit sampled on that same edge is discarded.
  - When a hit makes match_cnt equal target: go to DONE. The done pulse coincides with the final match pulse.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. match_cnt holds until the next start.
- match_cnt never exceeds target, so it cannot wrap.
- Latency: the completing bit sampled at edge k gives match high during the cycle after edge k.
- Reset asserted mid-run returns immediately to reset values; the pattern reverts to RST_PAT.

Decomposition:
- Package seq_det_pkg holds:
  - FSM state encoding (IDLE=0, ARM=1, RUN=2, DONE=3, 2-bit).
  - Default constants (RST_PAT, default target).
- One sub-module, pat_match_core. It holds history, fill and compare logic, with inputs clr, shift, bit, pattern, overlap and output hit.
- seq_det_ctrl holds the FSM, configuration registers, counter and output registers.

Test Plan:
1. Reset, no cfg, target=1, start, then stream 1,1,1,1,0 -> match and done high in the cycle after the 5th bit; match_cnt=1; busy drops.
2. cfg pattern=1010, overlap=1, target=2, stream 1,0,1,0,1,0 -> match after bits 4 and 6; done with the 2nd; match_cnt=2.
3. Same stream with overlap=0 and target=2 -> one match (bit 4); no done; abort -> IDLE, no done, match_cnt stays 1.
4. target=0, start -> ARM, then DONE next cycle; done pulse; match_cnt=0; no match.
5. RUN with in_valid toggling 1,0,1,0,... over pattern 1110 bits -> the match is delayed only by the valid gaps; cfg_we and start pulses during RUN are ignored (pattern unchanged, count not cleared).
6. Assert rst mid-RUN after 3 pattern bits -> all outputs 0 asynchronously; pattern=1110; a subsequent start with stream 0,1,1,1,0 -> single match after the 5th bit.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared FSM encoding and reset defaults for the sequence-detector controller.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0]  DEF_RST_PAT = 4'b1110;
  localparam int unsigned DEF_TARGET  = 1;

endpackage

// File: rtl/pat_match_core.sv
// Serial history shift register, fill tracker and pattern compare.
// o_hit looks at the post-shift history, so the owner can register a
// match in the same edge that samples the completing bit.
module pat_match_core
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_bit,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic             i_overlap,
  output logic             o_hit
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]  w_hist_next;
  logic [FILL_W-1:0] w_fill_next;

  // Next history/fill and the hit decision on the shifted-in value.
  always_comb begin
    w_hist_next = {r_hist[PAT_W-2:0], i_bit};
    w_fill_next = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
    o_hit       = i_shift && (w_fill_next == FILL_FULL) && (w_hist_next == i_pattern);
  end

  // History and fill; a non-overlapping hit restarts the fill count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_hist <= w_hist_next;
      r_fill <= (o_hit && !i_overlap) ? '0 : w_fill_next;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector controller: configuration,
// run sequencing, match counting and registered status outputs.
//
// state | meaning
// IDLE  | accepts configuration writes and start
// ARM   | one-cycle setup, serial input ignored, zero target finishes here
// RUN   | sampling qualified bits and counting hits
// DONE  | one-cycle completion pulse, then back to IDLE
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = DEF_RST_PAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cfg_we,
  input  logic [PAT_W-1:0] i_cfg_pattern,
  input  logic             i_cfg_overlap,
  input  logic [CNT_W-1:0] i_cfg_target,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_in,
  input  logic             i_in_valid,
  output logic             o_busy,
  output logic             o_match,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic             o_done
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PAT_W-1:0] r_pattern;
  logic             r_overlap;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_match_cnt;
  logic             r_busy;
  logic             r_match;
  logic             r_done;

  logic             w_go;
  logic             w_clr;
  logic             w_shift;
  logic             w_hit;
  logic             w_count;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_busy_nxt;
  logic             w_match_nxt;
  logic             w_done_nxt;

  // Abort always wins over start; a hit is only counted if not aborted.
  always_comb begin
    w_go      = i_start && !i_abort;
    w_clr     = (r_state == ST_IDLE) && w_go;
    w_shift   = (r_state == ST_RUN) && i_in_valid;
    w_count   = w_hit && !i_abort;
    w_cnt_inc = r_match_cnt + 1'b1;
    w_last    = w_count && (w_cnt_inc == r_target);
  end

  pat_match_core #(
    .PAT_W (PAT_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_shift   (w_shift),
    .i_bit     (i_in),
    .i_pattern (r_pattern),
    .i_overlap (r_overlap),
    .o_hit     (w_hit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_go) w_state_nxt = ST_ARM;
      ST_ARM:  w_state_nxt = (r_target == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (i_abort)     w_state_nxt = ST_IDLE;
        else if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the state being entered, so outputs are registered.
  always_comb begin
    w_busy_nxt  = (w_state_nxt == ST_ARM) || (w_state_nxt == ST_RUN);
    w_done_nxt  = (w_state_nxt == ST_DONE);
    w_match_nxt = w_count;
  end

  // Configuration registers, writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern <= RST_PAT;
      r_overlap <= 1'b0;
      r_target  <= CNT_W'(DEF_TARGET);
    end else if ((r_state == ST_IDLE) && i_cfg_we) begin
      r_pattern <= i_cfg_pattern;
      r_overlap <= i_cfg_overlap;
      r_target  <= i_cfg_target;
    end
  end

  // Match counter; cleared on start, stops at target because RUN exits there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_match_cnt <= '0;
    else if (w_clr)   r_match_cnt <= '0;
    else if (w_count) r_match_cnt <= w_cnt_inc;
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_match <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_match <= w_match_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_busy      = r_busy;
  assign o_match     = r_match;
  assign o_match_cnt = r_match_cnt;
  assign o_done      = r_done;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: per-cycle vector table plus
// hand-written sequences for valid gaps, ignored commands and reset.
module tb_seq_det_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [3:0] cfg_pattern;
  logic       cfg_overlap;
  logic [7:0] cfg_target;
  logic       start;
  logic       abort;
  logic       in_bit;
  logic       in_valid;
  logic       busy;
  logic       match;
  logic [7:0] match_cnt;
  logic       done;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       we;
    logic [3:0] pat;
    logic       ovl;
    logic [7:0] tgt;
    logic       st;
    logic       ab;
    logic       b;
    logic       vld;
    logic       e_busy;
    logic       e_match;
    logic [7:0] e_cnt;
    logic       e_done;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  seq_det_ctrl #(
    .PAT_W   (4),
    .CNT_W   (8),
    .RST_PAT (4'b1110)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cfg_we      (cfg_we),
    .i_cfg_pattern (cfg_pattern),
    .i_cfg_overlap (cfg_overlap),
    .i_cfg_target  (cfg_target),
    .i_start       (start),
    .i_abort       (abort),
    .i_in          (in_bit),
    .i_in_valid    (in_valid),
    .o_busy        (busy),
    .o_match       (match),
    .o_match_cnt   (match_cnt),
    .o_done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic we, input logic [3:0] pat, input logic ovl,
                              input logic [7:0] tgt, input logic st, input logic ab,
                              input logic b, input logic vld, input logic eb,
                              input logic em, input logic [7:0] ec, input logic ed,
                              input string nm);
    vec_t v;
    v.we = we; v.pat = pat; v.ovl = ovl; v.tgt = tgt; v.st = st; v.ab = ab;
    v.b = b; v.vld = vld; v.e_busy = eb; v.e_match = em; v.e_cnt = ec; v.e_done = ed;
    v.nm = nm;
    return v;
  endfunction

  task automatic chk(input string nm, input string sig, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h at %0t", nm, sig, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string nm, input logic eb, input logic em,
                          input logic [7:0] ec, input logic ed);
    chk(nm, "busy",      {7'd0, busy},  {7'd0, eb});
    chk(nm, "match",     {7'd0, match}, {7'd0, em});
    chk(nm, "match_cnt", match_cnt,     ec);
    chk(nm, "done",      {7'd0, done},  {7'd0, ed});
  endtask

  // Drive one cycle of inputs, clock it, then check outputs 1ns after the edge.
  task automatic step(input vec_t v);
    cfg_we = v.we; cfg_pattern = v.pat; cfg_overlap = v.ovl; cfg_target = v.tgt;
    start = v.st; abort = v.ab; in_bit = v.b; in_valid = v.vld;
    @(posedge clk);
    #1;
    chk_outs(v.nm, v.e_busy, v.e_match, v.e_cnt, v.e_done);
  endtask

  initial begin
    // Cycle table: inputs applied before the edge, outputs expected after it.
    // Test 1: reset config (1110, non-overlap, target 1), stream 1,1,1,1,0
    tbl.push_back(mk(0,4'h0,0,8'd0, 1,0,0,0, 1,0,8'd0,0, "t1_arm"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,0,0, 1,0,8'd0,0, "t1_run"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd0,0, "t1_b1"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd0,0, "t1_b2"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd0,0, "t1_b3"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd0,0, "t1_b4"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,0,1, 0,1,8'd1,1, "t1_hit_done"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,0,0, 0,0,8'd1,0, "t1_idle"));
    // Test 2: 1010 overlapping, target 2
    tbl.push_back(mk(1,4'hA,1,8'd2, 0,0,0,0, 0,0,8'd1,0, "t2_cfg"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 1,0,0,0, 1,0,8'd0,0, "t2_arm"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,0,0, 1,0,8'd0,0, "t2_run"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd0,0, "t2_b1"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,0,1, 1,0,8'd0,0, "t2_b2"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd0,0, "t2_b3"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,0,1, 1,1,8'd1,0, "t2_hit1"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd1,0, "t2_b5"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,0,1, 0,1,8'd2,1, "t2_hit2_done"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,0,0, 0,0,8'd2,0, "t2_idle"));
    // Test 3: same stream non-overlapping, then abort
    tbl.push_back(mk(1,4'hA,0,8'd2, 0,0,0,0, 0,0,8'd2,0, "t3_cfg"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 1,0,0,0, 1,0,8'd0,0, "t3_arm"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,0,0, 1,0,8'd0,0, "t3_run"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd0,0, "t3_b1"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,0,1, 1,0,8'd0,0, "t3_b2"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd0,0, "t3_b3"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,0,1, 1,1,8'd1,0, "t3_hit1"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd1,0, "t3_b5"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,0,1, 1,0,8'd1,0, "t3_no_overlap"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,1,0,0, 0,0,8'd1,0, "t3_abort"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,0,0, 0,0,8'd1,0, "t3_idle"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 1,1,0,0, 0,0,8'd1,0, "t3_abort_over_start"));
    // Test 4: target 0 written together with start
    tbl.push_back(mk(1,4'hA,0,8'd0, 1,0,0,0, 1,0,8'd0,0, "t4_cfg_start_arm"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,1,1, 0,0,8'd0,1, "t4_done"));
    tbl.push_back(mk(0,4'h0,0,8'd0, 0,0,0,0, 0,0,8'd0,0, "t4_idle"));

    rst_n = 1'b0;
    cfg_we = 0; cfg_pattern = 4'h0; cfg_overlap = 0; cfg_target = 8'd0;
    start = 0; abort = 0; in_bit = 0; in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 0, 0, 8'd0, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i]);

    // Test 5: valid gaps; cfg_we and start during RUN are ignored
    step(mk(1,4'hE,0,8'd2, 0,0,0,0, 0,0,8'd0,0, "t5_cfg"));
    step(mk(0,4'h0,0,8'd0, 1,0,0,0, 1,0,8'd0,0, "t5_arm"));
    step(mk(0,4'h0,0,8'd0, 0,0,0,0, 1,0,8'd0,0, "t5_run"));
    step(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd0,0, "t5_b1"));
    step(mk(1,4'h0,1,8'd1, 0,0,0,0, 1,0,8'd0,0, "t5_cfg_ignored"));
    step(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd0,0, "t5_b2"));
    step(mk(0,4'h0,0,8'd0, 1,0,0,0, 1,0,8'd0,0, "t5_start_ignored_a"));
    step(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd0,0, "t5_b3"));
    step(mk(0,4'h0,0,8'd0, 0,0,1,0, 1,0,8'd0,0, "t5_gap"));
    step(mk(0,4'h0,0,8'd0, 0,0,0,1, 1,1,8'd1,0, "t5_hit"));
    step(mk(0,4'h0,0,8'd0, 1,0,0,0, 1,0,8'd1,0, "t5_start_ignored_b"));
    step(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd1,0, "t5_b5"));
    step(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd1,0, "t5_b6"));
    step(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd1,0, "t5_b7"));
    step(mk(0,4'h0,0,8'd0, 0,1,0,1, 0,0,8'd1,0, "t5_abort_hit_discard"));
    step(mk(0,4'h0,0,8'd0, 0,0,0,0, 0,0,8'd1,0, "t5_idle"));

    // Test 6: reset mid-run restores RST_PAT and target 1
    step(mk(1,4'h7,1,8'd3, 0,0,0,0, 0,0,8'd1,0, "t6_cfg"));
    step(mk(0,4'h0,0,8'd0, 1,0,0,0, 1,0,8'd0,0, "t6_arm"));
    step(mk(0,4'h0,0,8'd0, 0,0,0,0, 1,0,8'd0,0, "t6_run"));
    step(mk(0,4'h0,0,8'd0, 0,0,0,1, 1,0,8'd0,0, "t6_b1"));
    step(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd0,0, "t6_b2"));
    step(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd0,0, "t6_b3"));
    step(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,1,8'd1,0, "t6_pre_hit"));
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1 chk_outs("t6_async_reset", 0, 0, 8'd0, 0);
    #3 rst_n = 1'b1;
    step(mk(0,4'h0,0,8'd0, 1,0,0,0, 1,0,8'd0,0, "t6_arm2"));
    step(mk(0,4'h0,0,8'd0, 0,0,0,0, 1,0,8'd0,0, "t6_run2"));
    step(mk(0,4'h0,0,8'd0, 0,0,0,1, 1,0,8'd0,0, "t6_c1"));
    step(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd0,0, "t6_c2"));
    step(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd0,0, "t6_c3"));
    step(mk(0,4'h0,0,8'd0, 0,0,1,1, 1,0,8'd0,0, "t6_c4_no_old_pat"));
    step(mk(0,4'h0,0,8'd0, 0,0,0,1, 0,1,8'd1,1, "t6_hit_done"));
    step(mk(0,4'h0,0,8'd0, 0,0,0,0, 0,0,8'd1,0, "t6_idle"));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
